// File: rtl/serdes_pkg.sv
// Shared types and default words for the SERDES TX link sequencer.
package serdes_pkg;

   typedef enum logic [1:0] {
      KIND_IDLE  = 2'd0,
      KIND_TRAIN = 2'd1,
      KIND_SYNC  = 2'd2,
      KIND_DATA  = 2'd3
   } tx_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRAIN  = 3'd1,
      ST_SYNC   = 3'd2,
      ST_DATA   = 3'd3,
      ST_RESYNC = 3'd4
   } sched_state_e;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] DEF_TRAIN_WORD = 32'hAAAA_AAAA;
   localparam logic [WORD_W-1:0] DEF_SYNC_WORD  = 32'hBCBC_BCBC;
   localparam logic [WORD_W-1:0] DEF_IDLE_WORD  = 32'h0000_0000;

endpackage

// File: rtl/serdes_tx_sched_map.sv
// Per-byte bit remap: even input bits fill the upper nibble, odd bits the lower, both reversed.
module serdes_tx_sched_map
   import serdes_pkg::*;
(
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   localparam int unsigned NUM_BYTES = WORD_W / 8;

   for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
      assign dout[8*b +: 8] = {din[8*b+0], din[8*b+2], din[8*b+4], din[8*b+6],
                               din[8*b+1], din[8*b+3], din[8*b+5], din[8*b+7]};
   end

endmodule

// File: rtl/serdes_tx_sched.sv
// TX link sequencer: TRAIN/SYNC bring-up, then user DATA with IDLE fill and periodic RESYNC.
module serdes_tx_sched
   import serdes_pkg::*;
#(
   parameter int unsigned       TRAIN_LEN  = 64,
   parameter int unsigned       SYNC_LEN   = 4,
   parameter int unsigned       FRAME_LEN  = 1024,
   parameter logic [WORD_W-1:0] TRAIN_WORD = DEF_TRAIN_WORD,
   parameter logic [WORD_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
   parameter logic [WORD_W-1:0] IDLE_WORD  = DEF_IDLE_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              link_en,
   input  logic              start,
   input  logic              map_en,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [WORD_W-1:0] tx_data,
   output logic [1:0]        tx_kind,
   output logic              busy
);

   localparam int unsigned CNT_MAX = (TRAIN_LEN > SYNC_LEN) ? TRAIN_LEN : SYNC_LEN;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned DCNT_W  = $clog2(FRAME_LEN);

   sched_state_e        state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [DCNT_W-1:0]   dcnt, dcnt_n;
   logic                map_en_q, map_en_q_n;
   logic [WORD_W-1:0]   sel, sel_mapped;
   tx_kind_e            sel_kind;
   logic                xfer;

   assign s_ready = (state == ST_DATA) && link_en;
   assign busy    = (state != ST_IDLE);
   assign xfer    = s_valid && s_ready;

   serdes_tx_sched_map u_map (
      .din  (sel),
      .dout (sel_mapped)
   );

   // State, counters and the emitted-word register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         dcnt     <= '0;
         map_en_q <= 1'b0;
         tx_data  <= '0;
         tx_kind  <= 2'(KIND_IDLE);
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dcnt     <= dcnt_n;
         map_en_q <= map_en_q_n;
         tx_data  <= map_en_q ? sel_mapped : sel;
         tx_kind  <= 2'(sel_kind);
      end
   end

   // Next state and word selection from the pre-edge state.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      dcnt_n     = dcnt;
      map_en_q_n = map_en_q;
      sel        = IDLE_WORD;
      sel_kind   = KIND_IDLE;

      case (state)
         ST_IDLE: begin
            if (start && link_en) begin
               state_n    = ST_TRAIN;
               map_en_q_n = map_en;
               cnt_n      = '0;
            end
         end
         ST_TRAIN: begin
            sel      = TRAIN_WORD;
            sel_kind = KIND_TRAIN;
            if (cnt == CNT_W'(TRAIN_LEN - 1)) begin
               state_n = ST_SYNC;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_SYNC: begin
            sel      = SYNC_WORD;
            sel_kind = KIND_SYNC;
            if (cnt == CNT_W'(SYNC_LEN - 1)) begin
               state_n = ST_DATA;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (xfer) begin
               sel      = s_data;
               sel_kind = KIND_DATA;
               if (dcnt == DCNT_W'(FRAME_LEN - 1)) begin
                  state_n = ST_RESYNC;
                  dcnt_n  = '0;
               end else begin
                  dcnt_n = dcnt + DCNT_W'(1);
               end
            end
         end
         ST_RESYNC: begin
            sel      = SYNC_WORD;
            sel_kind = KIND_SYNC;
            state_n  = ST_DATA;
         end
         default: state_n = ST_IDLE;
      endcase

      // Link drop wins over any transition; the word for this edge is already chosen.
      if (!link_en) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         dcnt_n  = '0;
      end
   end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Self-checking bench for serdes_tx_sched: directed bring-up scenarios plus randomized traffic.
module tb_serdes_tx_sched;

   localparam int unsigned T_LEN = 4;
   localparam int unsigned S_LEN = 2;
   localparam int unsigned F_LEN = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_en, start, map_en, s_valid;
   logic [31:0] s_data;
   logic        s_ready, busy;
   logic [31:0] tx_data;
   logic [1:0]  tx_kind;

   int checks = 0;
   int errors = 0;

   // Reference model: position in bring-up sequence and data words since last resync.
   bit m_active;
   int m_pos;
   int m_ndata;
   bit m_pend;
   bit m_map;

   always #5 clk = ~clk;

   serdes_tx_sched #(
      .TRAIN_LEN (T_LEN),
      .SYNC_LEN  (S_LEN),
      .FRAME_LEN (F_LEN)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .link_en (link_en),
      .start   (start),
      .map_en  (map_en),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .tx_data (tx_data),
      .tx_kind (tx_kind),
      .busy    (busy)
   );

   function automatic logic [31:0] remap(input logic [31:0] w);
      int dst[8] = '{7, 3, 6, 2, 5, 1, 4, 0};
      logic [31:0] r = '0;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 8; i++)
            r[8*b + dst[i]] = w[8*b + i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pos = 0; m_ndata = 0; m_pend = 0; m_map = 0;
   endtask

   // One clock cycle: drive inputs, check combinational outputs, then the registered word.
   task automatic step(input logic le, input logic st, input logic me,
                       input logic sv, input logic [31:0] sd);
      logic        e_ready;
      logic [31:0] e_word;
      logic [1:0]  e_kind;
      bit          map_used;
      @(negedge clk);
      link_en = le; start = st; map_en = me; s_valid = sv; s_data = sd;
      #1;
      e_ready = m_active && (m_pos >= T_LEN + S_LEN) && !m_pend && le;
      chk("s_ready", 32'(s_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(m_active));
      map_used = m_map;
      e_word = 32'h0; e_kind = 2'd0;
      if (!m_active) begin
         if (st && le) begin
            m_active = 1; m_pos = 0; m_ndata = 0; m_pend = 0; m_map = me;
         end
      end else begin
         if (m_pos < T_LEN) begin
            e_word = 32'hAAAA_AAAA; e_kind = 2'd1;
         end else if (m_pos < T_LEN + S_LEN) begin
            e_word = 32'hBCBC_BCBC; e_kind = 2'd2;
         end else if (m_pend) begin
            e_word = 32'hBCBC_BCBC; e_kind = 2'd2; m_pend = 0;
         end else if (sv && e_ready) begin
            e_word = sd; e_kind = 2'd3;
            m_ndata++;
            if (m_ndata == F_LEN) begin
               m_pend = 1; m_ndata = 0;
            end
         end
         if (m_pos < T_LEN + S_LEN) m_pos++;
         if (!le) m_active = 0;
      end
      @(posedge clk);
      #1;
      chk("tx_data", tx_data, map_used ? remap(e_word) : e_word);
      chk("tx_kind", 32'(tx_kind), 32'(e_kind));
   endtask

   initial begin
      rst_n = 1'b0; link_en = 1'b1; start = 1'b0; map_en = 1'b0;
      s_valid = 1'b0; s_data = '0;
      model_reset();

      // Reset held three cycles.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_tx_data", tx_data, 32'h0);
         chk("rst_tx_kind", 32'(tx_kind), 32'h0);
         chk("rst_s_ready", 32'(s_ready), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0);

      // Mapped bring-up.
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < T_LEN; i++) begin
         step(1, 0, 0, 0, 0);
         chk("train_mapped", tx_data, 32'h0F0F_0F0F);
      end
      for (int i = 0; i < S_LEN; i++) begin
         step(1, 0, 0, 0, 0);
         chk("sync_mapped", tx_data, 32'h6767_6767);
      end
      step(1, 0, 0, 1, 32'h0000_0001);
      chk("data_mapped", tx_data, 32'h0000_0080);
      chk("data_kind", 32'(tx_kind), 32'd3);
      step(1, 0, 0, 0, 32'h1234_5678);
      chk("gap_idle", tx_data, 32'h0);

      // Unmapped bring-up, then continuous data across resync boundaries.
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < T_LEN + S_LEN; i++) step(1, 0, 1, 0, 0);
      for (int i = 0; i < 3 * (F_LEN + 1); i++) step(1, 0, 1, 1, 32'hD000_0000 + 32'(i));

      // Link drop mid-DATA, start during DATA, and start with link down.
      step(1, 1, 1, 1, 32'hCAFE_0001);
      step(0, 0, 0, 1, 32'hCAFE_0002);
      step(0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);

      // Link drop mid-TRAIN, then full replay.
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < T_LEN + S_LEN + 2; i++) step(1, 0, 0, 1, $urandom);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 19) == 0),
              1'($urandom), ($urandom_range(0, 9) < 7), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
